display_scan: RTL

- Scan controller and 7-segment driver directly downstream of the registered 4-way digit selector.
- Drives the selector's 2-bit select and consumes its 5-bit registered output.
- Produces active-low anode enables and segment lines for a 4-digit common-anode display.
- Inserts a blanking gap on every digit change to cover the selector latency and suppress ghosting.

---
 rtl/display_pkg.sv | 42 ++++
 rtl/seg7_decode.sv | 14 +
 rtl/display_scan.sv | 119 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared state type, segment patterns and blanking constants for the display scan
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  // Indexed by the hex digit value
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
    SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
    SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
    SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex digit to active-low 7-segment pattern
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Straight table lookup; every 4-bit value has a defined glyph
  always_comb begin
    seg_n = SEG_PATTERNS[hex];
  end

endmodule

// File: rtl/display_scan.sv
// rtl/display_scan.sv - 4-digit common-anode scan controller with blanking gap and registered outputs
module display_scan
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int MUX_LATENCY  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [4:0] dig_in,
  output logic [1:0] sel,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       frame_tick
);

  // The blank must outlast the selector latency so the captured value is never stale
  localparam int BEFF    = max_int(BLANK_CYCLES, MUX_LATENCY + 1);
  localparam int CNT_MAX = max_int(BEFF, DWELL_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BEFF - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DWELL_CYCLES - 1);

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [4:0]    dig_q, dig_d;
  logic [3:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          tick_q, tick_d;
  logic [6:0]    dec_seg_n;

  // Decode the value that will be held next cycle so the pattern can be registered alongside it
  seg7_decode u_seg7_decode (
    .hex   (dig_d[3:0]),
    .seg_n (dec_seg_n)
  );

  // Next-state: blank/show sequencing, digit capture, index advance; disable wins over everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    tick_d  = 1'b0;
    if (!en) begin
      state_d = BLANK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            dig_d   = dig_in;
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            idx_d   = idx_q + 2'd1;
            tick_d  = (idx_q == 2'd3);
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output values follow the next state so the pins change on the same edge as the state
  always_comb begin
    an_n_d  = AN_OFF;
    seg_n_d = SEG_OFF;
    if (state_d == SHOW) begin
      an_n_d = ~(4'b0001 << idx_d);
      if (dig_d[4]) begin
        seg_n_d = dec_seg_n;
      end
    end
  end

  // State and output registers; reset forces the display dark immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      dig_q   <= 5'd0;
      an_n_q  <= AN_OFF;
      seg_n_q <= SEG_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
      tick_q  <= tick_d;
    end
  end

  assign sel        = idx_q;
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign frame_tick = tick_q;

endmodule
